// File: rtl/apb_cmd_pkg.sv
// Shared types and constants for the APB command requester of the timer subsystem.
package apb_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    // timer_top register map
    localparam logic [ADDR_W_DEF-1:0] TCR_ADDR   = 12'h000;
    localparam logic [ADDR_W_DEF-1:0] TDR0_ADDR  = 12'h004;
    localparam logic [ADDR_W_DEF-1:0] TDR1_ADDR  = 12'h008;
    localparam logic [ADDR_W_DEF-1:0] TCMP0_ADDR = 12'h00C;
    localparam logic [ADDR_W_DEF-1:0] TCMP1_ADDR = 12'h010;
    localparam logic [ADDR_W_DEF-1:0] TIER_ADDR  = 12'h014;
    localparam logic [ADDR_W_DEF-1:0] TISR_ADDR  = 12'h018;
    localparam logic [ADDR_W_DEF-1:0] THCSR_ADDR = 12'h01C;

endpackage

// File: rtl/apb_cmd_master.sv
// Turns a valid/ready command stream into single APB4 transfers and returns a response.
// Latency: command accept -> rsp_valid is 2 cycles plus one per pready wait state.
// Backpressure: one transfer in flight; cmd_ready low until the response is consumed.
module apb_cmd_master
    import apb_cmd_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                tim_psel,
    output logic                tim_penable,
    output logic                tim_pwrite,
    output logic [ADDR_W-1:0]   tim_paddr,
    output logic [DATA_W-1:0]   tim_pwdata,
    output logic [DATA_W/8-1:0] tim_pstrb,
    input  logic [DATA_W-1:0]   tim_prdata,
    input  logic                tim_pready,
    input  logic                tim_pslverr,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } cmd_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              timeout;
    } rsp_t;

    state_t           state;
    state_t           state_nxt;
    cmd_t             cmd_q;
    rsp_t             rsp_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             cmd_take;
    logic             timeout_hit;
    logic             bus_act;

    assign cmd_take    = (state == IDLE) && cmd_valid;
    // pready in the threshold cycle takes priority over the abort
    assign timeout_hit = TO_EN && !tim_pready && (wait_cnt == CNT_LAST);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (tim_pready || timeout_hit) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cmd_q    <= '0;
            rsp_q    <= '0;
            wait_cnt <= '0;
        end else begin
            if (cmd_take) begin
                cmd_q.write <= cmd_write;
                cmd_q.addr  <= cmd_addr;
                // reads carry zero data and strobes onto the bus
                cmd_q.wdata <= cmd_write ? cmd_wdata : '0;
                cmd_q.strb  <= cmd_write ? cmd_strb : '0;
            end

            if (state == SETUP) begin
                wait_cnt <= '0;
            end else if ((state == ACCESS) && !tim_pready) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            if (state == ACCESS) begin
                if (tim_pready) begin
                    rsp_q.rdata   <= cmd_q.write ? '0 : tim_prdata;
                    rsp_q.err     <= tim_pslverr;
                    rsp_q.timeout <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_q.rdata   <= '0;
                    rsp_q.err     <= 1'b1;
                    rsp_q.timeout <= 1'b1;
                end
            end
        end
    end

    assign bus_act     = (state == SETUP) || (state == ACCESS);
    assign cmd_ready   = (state == IDLE);
    assign busy        = (state != IDLE);

    assign tim_psel    = bus_act;
    assign tim_penable = (state == ACCESS);
    assign tim_pwrite  = bus_act && cmd_q.write;
    assign tim_paddr   = bus_act ? cmd_q.addr : '0;
    assign tim_pwdata  = bus_act ? cmd_q.wdata : '0;
    assign tim_pstrb   = bus_act ? cmd_q.strb : '0;

    assign rsp_valid   = (state == RESP);
    assign rsp_rdata   = rsp_valid ? rsp_q.rdata : '0;
    assign rsp_err     = rsp_valid && rsp_q.err;
    assign rsp_timeout = rsp_valid && rsp_q.timeout;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: RAM-like timer slave, vector table, directed corners, random traffic.
module tb_apb_cmd_master;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [11:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        tim_psel;
    logic        tim_penable;
    logic        tim_pwrite;
    logic [11:0] tim_paddr;
    logic [31:0] tim_pwdata;
    logic [3:0]  tim_pstrb;
    logic [31:0] tim_prdata = '0;
    logic        tim_pready = 1'b0;
    logic        tim_pslverr = 1'b0;
    logic        busy;

    int errors = 0;
    int checks = 0;

    apb_cmd_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(16)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
        .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
        .tim_prdata(tim_prdata), .tim_pready(tim_pready), .tim_pslverr(tim_pslverr),
        .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- slave: register RAM with configurable wait states ----------------
    logic [31:0] smem [8];
    int          slv_wait = 0;
    logic        slv_err = 1'b0;
    logic        slv_never = 1'b0;
    int          sacc = 0;

    always @(negedge sys_clk) begin
        if (tim_psel && tim_penable) begin
            if (!slv_never && sacc == slv_wait) begin
                tim_pready  = 1'b1;
                tim_pslverr = slv_err;
                tim_prdata  = tim_pwrite ? $urandom : smem[tim_paddr[4:2]];
                if (tim_pwrite && !slv_err)
                    for (int b = 0; b < 4; b++)
                        if (tim_pstrb[b]) smem[tim_paddr[4:2]][8*b +: 8] = tim_pwdata[8*b +: 8];
            end else begin
                // noise on data/error while not ready must be ignored
                tim_pready  = 1'b0;
                tim_pslverr = 1'($urandom % 2);
                tim_prdata  = $urandom;
            end
            sacc++;
        end else begin
            sacc        = 0;
            tim_pready  = 1'b0;
            tim_pslverr = 1'b0;
            tim_prdata  = '0;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] mdl [8];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    task automatic model_apply(input logic w, input logic [11:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic err, input logic nev);
        if (w && !err && !nev) mdl[a[4:2]] = merge(mdl[a[4:2]], d, s);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- one full transaction ----------------
    task automatic xfer(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int waits, input logic err, input logic nev, input int rdly,
                        output logic [31:0] rd, output logic e, output logic to, output int acc);
        int   n;
        logic bus_ok;
        logic hold_ok;
        slv_wait  = waits;
        slv_err   = err;
        slv_never = nev;
        rsp_ready = (rdly == 0);
        acc = 0;
        n = 0;
        @(negedge sys_clk);
        while (!cmd_ready && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom); cmd_addr = 12'($urandom); cmd_wdata = $urandom; cmd_strb = 4'($urandom);
        bus_ok = 1'b1;
        n = 0;
        while (!rsp_valid && n < 100) begin
            if (!tim_psel || tim_paddr !== a || tim_pwrite !== w ||
                tim_pwdata !== (w ? d : 32'h0) || tim_pstrb !== (w ? s : 4'h0)) bus_ok = 1'b0;
            if (tim_psel && tim_penable) acc++;
            @(negedge sys_clk);
            n++;
        end
        chk("bus_fields", 32'(bus_ok), 32'd1);
        chk("rsp_arrived", 32'(rsp_valid), 32'd1);
        chk("resp_bus_idle", 32'({tim_psel, tim_penable, tim_pwrite, |tim_paddr, |tim_pwdata,
                                  |tim_pstrb, cmd_ready, busy}), 32'h01);
        rd = rsp_rdata;
        e  = rsp_err;
        to = rsp_timeout;
        hold_ok = 1'b1;
        for (int k = 0; k < rdly; k++) begin
            cmd_valid = 1'b1;
            @(negedge sys_clk);
            if (!rsp_valid || rsp_rdata !== rd || rsp_err !== e || rsp_timeout !== to || cmd_ready !== 1'b0)
                hold_ok = 1'b0;
        end
        cmd_valid = 1'b0;
        if (rdly > 0) chk("rsp_hold", 32'(hold_ok), 32'd1);
        rsp_ready = 1'b1;
        @(negedge sys_clk);
        chk("back_to_idle", 32'({rsp_valid, cmd_ready}), 32'b01);
    endtask

    typedef struct {
        logic        w;
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          waits;
        logic        err;
        logic        nev;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        exp_to;
        int          exp_acc;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [31:0] rd;
        logic        e, to, rv_seen;
        int          acc;
        logic        w, err, nev;
        logic [2:0]  idx;
        logic [11:0] a;
        logic [31:0] d, exp_rd;
        logic [3:0]  s;
        int          waits, rdly;

        //            w     addr     data          strb  wt err   never  exp_rd        err   to    acc
        vecs[0]  = '{1'b0, 12'h00C, 32'h0,        4'h0, 0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1};
        vecs[1]  = '{1'b0, 12'h000, 32'h0,        4'h0, 0, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1};
        vecs[2]  = '{1'b1, 12'h000, 32'h1,        4'hF, 0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1};
        vecs[3]  = '{1'b0, 12'h000, 32'h0,        4'h0, 0, 1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1};
        vecs[4]  = '{1'b0, 12'h014, 32'h0,        4'h0, 3, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 4};
        vecs[5]  = '{1'b0, 12'h01C, 32'h0,        4'h0, 0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 16};
        vecs[6]  = '{1'b1, 12'h010, 32'h1234_5678, 4'h5, 0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1};
        vecs[7]  = '{1'b0, 12'h010, 32'h0,        4'h0, 0, 1'b0, 1'b0, 32'hFF34_FF78, 1'b0, 1'b0, 1};
        vecs[8]  = '{1'b1, 12'h014, 32'h0000_00AA, 4'h1, 2, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 3};
        vecs[9]  = '{1'b0, 12'h014, 32'h0,        4'h0, 0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1};
        vecs[10] = '{1'b1, 12'h018, 32'hDEAD_BEEF, 4'hF, 15, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 16};
        vecs[11] = '{1'b0, 12'h018, 32'h0,        4'h0, 1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2};

        for (int i = 0; i < 8; i++) begin
            smem[i] = '0;
            mdl[i]  = '0;
        end
        smem[0] = 32'h0000_0100; mdl[0] = 32'h0000_0100;
        smem[3] = 32'hFFFF_FFFF; mdl[3] = 32'hFFFF_FFFF;
        smem[4] = 32'hFFFF_FFFF; mdl[4] = 32'hFFFF_FFFF;

        // reset state
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("reset_outputs", 32'({tim_psel, tim_penable, tim_pwrite, |tim_paddr, |tim_pwdata, |tim_pstrb,
                                  rsp_valid, rsp_err, rsp_timeout, |rsp_rdata, busy}), 32'h0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        sys_rst_n = 1'b1;

        // vector table
        for (int i = 0; i < 12; i++) begin
            xfer(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, vecs[i].waits, vecs[i].err, vecs[i].nev, 0,
                 rd, e, to, acc);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_timeout", i), 32'(to), 32'(vecs[i].exp_to));
            chk($sformatf("vec%0d_access_cycles", i), 32'(acc), 32'(vecs[i].exp_acc));
            model_apply(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, vecs[i].err, vecs[i].nev);
        end

        // cycle-exact zero-wait write
        slv_wait = 0; slv_err = 1'b0; slv_never = 1'b0; rsp_ready = 1'b1;
        @(negedge sys_clk);
        chk("t_idle_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h008; cmd_wdata = 32'hA5A5_0001; cmd_strb = 4'hF;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        chk("t_setup", 32'({tim_psel, tim_penable, rsp_valid}), 32'b100);
        @(negedge sys_clk);
        chk("t_access", 32'({tim_psel, tim_penable, rsp_valid}), 32'b110);
        @(negedge sys_clk);
        chk("t_resp", 32'({tim_psel, tim_penable, rsp_valid, rsp_err, rsp_timeout}), 32'b00100);
        chk("t_resp_wdata_zero", rsp_rdata, 32'h0);
        @(negedge sys_clk);
        chk("t_idle_again", 32'({rsp_valid, cmd_ready}), 32'b01);
        model_apply(1'b1, 12'h008, 32'hA5A5_0001, 4'hF, 1'b0, 1'b0);

        // response held under backpressure for 5 cycles
        xfer(1'b0, 12'h008, 32'h0, 4'h0, 0, 1'b0, 1'b0, 5, rd, e, to, acc);
        chk("hold_rdata", rd, 32'hA5A5_0001);
        chk("hold_err", 32'({e, to}), 32'b00);

        // reset during ACCESS
        slv_never = 1'b1;
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h000;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        @(negedge sys_clk);
        chk("mid_in_access", 32'(tim_penable), 32'd1);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        chk("mid_rst_bus", 32'({tim_psel, tim_penable, busy, rsp_valid}), 32'b0000);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        sys_rst_n = 1'b1;
        slv_never = 1'b0;
        rv_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            rv_seen = rv_seen | rsp_valid;
        end
        chk("mid_rst_no_rsp", 32'(rv_seen), 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 80; i++) begin
            w     = 1'($urandom % 2);
            idx   = 3'($urandom % 8);
            a     = {7'd0, idx, 2'b00};
            d     = $urandom;
            s     = 4'($urandom % 16);
            nev   = ($urandom % 8) == 0;
            err   = ($urandom % 5) == 0;
            waits = int'($urandom % 5);
            rdly  = int'($urandom % 4);
            exp_rd = (nev || w) ? 32'h0 : mdl[idx];
            xfer(w, a, d, s, waits, err, nev, rdly, rd, e, to, acc);
            chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
            chk($sformatf("rnd%0d_err", i), 32'(e), 32'(nev | err));
            chk($sformatf("rnd%0d_timeout", i), 32'(to), 32'(nev));
            chk($sformatf("rnd%0d_access_cycles", i), 32'(acc), nev ? 32'd16 : 32'(waits + 1));
            model_apply(w, a, d, s, err, nev);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
